decode_writeback: RTL and testbench
===================================

// Module: decode_writeback
// PURPOSE
//  Y86-64 register file with decode-side read selection and write-back, for the single-cycle CPU.
//  - Feeds valA/valB to the execute stage.
//  - Takes valE from execute, valM from the memory stage, and Cnd from execute, and writes them back on the clock edge.
//  - Holds the sticky processor status (AOK/HLT/ADR/INS). When status is not AOK, all architectural writes stop.
// PARAMETERS
//  DATA_W    64  register and data width
//  NREG      15  architectural registers, ids 0..14; id 4'hF = RNONE
//  RSP_INIT  0   value loaded into %rsp (id 4) at reset
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       asynchronous, active-high reset
//  icode_i        in   4       instruction code from fetch
//  rA_i           in   4       rA field
//  rB_i           in   4       rB field
//  Cnd_i          in   1       condition result from execute (cmovXX)
//  valE_i         in   DATA_W  execute result
//  valM_i         in   DATA_W  memory read data
//  imem_err_i     in   1       fetch address error
//  dmem_err_i     in   1       data memory address error
//  valA_o         out  DATA_W  read data for srcA (0 when srcA = RNONE)
//  valB_o         out  DATA_W  read data for srcB (0 when srcB = RNONE)
//  dstE_o         out  4       selected E destination (observability)
//  dstM_o         out  4       selected M destination (observability)
//  stat_o         out  3       1=AOK 2=HLT 3=ADR 4=INS
//  dbg_addr_i     in   4       debug read address
//  dbg_data_o     out  DATA_W  debug read data (combinational)
// BEHAVIOUR
//  Reset:
//  - Async. All registers clear to 0, except %rsp, which loads RSP_INIT.
//  - stat_o = AOK.
//  - valA_o/valB_o/dbg_data_o follow the reset contents combinationally.
//  Source selection (combinational):
//  - srcA = rA for {2,4,6,A}; RSP for {9,B}; else RNONE.
//  - srcB = rB for {4,5,6}; RSP for {8,9,A,B}; else RNONE.
//  Destination selection (combinational):
//  - dstE = rB for 3, for 6, and for 2 when Cnd_i=1.
//  - dstE = RSP for {8,9,A,B}.
//  - dstE = RNONE for 2 when Cnd_i=0, and for all other icodes.
//  - dstM = rA for {5,B}; else RNONE.
//  Read path:
//  - Reads are asynchronous and return pre-edge contents.
//  - No write-to-read bypass; single-cycle sequencing makes it unnecessary.
//  - Reading id 4'hF returns 0.
//  Write-back at rising edge, only while stat = AOK and the next-status is AOK:
//  - reg[dstE] <= valE_i when dstE != RNONE.
//  - reg[dstM] <= valM_i when dstM != RNONE.
//  - If dstE == dstM (popq %rsp), the M port wins: the result is valM_i.
//  - Latency: 1 clock from inputs to visible register contents.
//  Status FSM (sticky), evaluated per edge while in AOK:
//  - imem_err_i -> ADR.
//  - else icode > 4'hB -> INS.
//  - else dmem_err_i -> ADR.
//  - else icode == 0 -> HLT.
//  - else stay AOK.
//  - The faulting or halting instruction performs no write.
//  - HLT/ADR/INS are absorbing; only rst_i returns to AOK.
//  Reset asserted mid-operation overrides any pending write in that cycle.
//  Arithmetic: none. Data passes through at full DATA_W with no truncation.
// STRUCTURE
//  Shared package:
//  - icode constants (IHALT..IPOPQ), RNONE, RRSP.
//  - STAT_AOK/HLT/ADR/INS encodings.
//  Sub-module: regfile_2r2w (NREG x DATA_W).
//  - Async reset, 2 async read ports plus the debug port, 2 write ports with M-port priority.
//  - This top holds the select logic and the status FSM.
// TESTING
//  - Reset with RSP_INIT=256 -> dbg reg4=256, all others 0, stat=1.
//  - icode=3 rB=3 valE=0x100, one edge -> reg3=0x100; valA/valB for icode=6 rA=3 rB=3 both read 0x100.
//  - icode=2 rA=3 rB=5 Cnd=0, valE=0x100 -> reg5 unchanged (0), dstE=F.
//  - Same cycle with Cnd=1 -> reg5=0x100.
//  - icode=B rA=4 valE=264 valM=0x55 -> reg4=0x55 (M priority); dstE=dstM=4.
//  - icode=A, then icode=0 -> push updates reg4.
//  - The halt edge performs no write; stat=2; a following icode=3 rB=1 valE=7 leaves reg1=0.
//  - icode=4'hC -> stat=4, no write. Assert rst_i asynchronously mid-cycle -> stat=1 immediately, regs cleared.
//  - dmem_err_i=1 with icode=5 rA=2 -> stat=3, reg2 unchanged.

Source files
------------

// File: rtl/decode_writeback_pkg.sv
// Shared Y86-64 decode/write-back definitions: instruction codes, register ids
// and processor status encodings.
package decode_writeback_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

endpackage

// File: rtl/decode_writeback_regfile.sv
// NREG x DATA_W register file: two async read ports plus a debug port, and two
// write ports where the M port overrides the E port on a shared destination.
module regfile_2r2w
  import decode_writeback_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                NREG     = 15,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we_e,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic              we_m,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m
);

  logic [DATA_W-1:0] regs [NREG];

  // Ids past the last architectural register (RNONE) read as zero.
  function automatic logic [DATA_W-1:0] rd(input logic [3:0] id);
    if (32'(id) < NREG) begin
      return regs[id];
    end else begin
      return '0;
    end
  endfunction

  assign val_a    = rd(src_a);
  assign val_b    = rd(src_b);
  assign dbg_data = rd(dbg_addr);

  // Register array update with M-port priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == int'(RRSP)) ? RSP_INIT : '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_m && (dst_m == 4'(i))) begin
          regs[i] <= val_m;
        end else if (we_e && (dst_e == 4'(i))) begin
          regs[i] <= val_e;
        end
      end
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode and write-back stage: register source/destination selection,
// the register file, and the sticky processor status.
module decode_writeback
  import decode_writeback_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                NREG     = 15,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        rA_i,
  input  logic [3:0]        rB_i,
  input  logic              Cnd_i,
  input  logic [DATA_W-1:0] valE_i,
  input  logic [DATA_W-1:0] valM_i,
  input  logic              imem_err_i,
  input  logic              dmem_err_i,
  output logic [DATA_W-1:0] valA_o,
  output logic [DATA_W-1:0] valB_o,
  output logic [3:0]        dstE_o,
  output logic [3:0]        dstM_o,
  output logic [2:0]        stat_o,
  input  logic [3:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [3:0] src_a, src_b, dst_e, dst_m;
  stat_t      stat_r, next_stat;
  logic       commit;

  // Register id selection from the instruction fields.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode_i)
      IRRMOVQ: begin
        src_a = rA_i;
        if (Cnd_i) begin
          dst_e = rB_i;
        end else begin
          dst_e = RNONE;
        end
      end
      IIRMOVQ: dst_e = rB_i;
      IRMMOVQ: begin src_a = rA_i; src_b = rB_i; end
      IMRMOVQ: begin src_b = rB_i; dst_m = rA_i; end
      IOPQ:    begin src_a = rA_i; src_b = rB_i; dst_e = rB_i; end
      ICALL:   begin src_b = RRSP; dst_e = RRSP; end
      IRET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
      IPUSHQ:  begin src_a = rA_i; src_b = RRSP; dst_e = RRSP; end
      IPOPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = rA_i; end
      default: begin src_a = RNONE; src_b = RNONE; dst_e = RNONE; dst_m = RNONE; end
    endcase
  end

  // Fault priority: fetch error, illegal icode, data error, then halt.
  always_comb begin
    if (imem_err_i) begin
      next_stat = STAT_ADR;
    end else if (icode_i > IPOPQ) begin
      next_stat = STAT_INS;
    end else if (dmem_err_i) begin
      next_stat = STAT_ADR;
    end else if (icode_i == IHALT) begin
      next_stat = STAT_HLT;
    end else begin
      next_stat = STAT_AOK;
    end
  end

  assign commit = (stat_r == STAT_AOK) && (next_stat == STAT_AOK);

  // Sticky status: any non-AOK state is held until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_r <= STAT_AOK;
    end else if (stat_r == STAT_AOK) begin
      stat_r <= next_stat;
    end else begin
      stat_r <= stat_r;
    end
  end

  regfile_2r2w #(
    .DATA_W  (DATA_W),
    .NREG    (NREG),
    .RSP_INIT(RSP_INIT)
  ) u_regfile (
    .clk     (clk_i),
    .rst     (rst_i),
    .src_a   (src_a),
    .src_b   (src_b),
    .dbg_addr(dbg_addr_i),
    .val_a   (valA_o),
    .val_b   (valB_o),
    .dbg_data(dbg_data_o),
    .we_e    (commit && (dst_e != RNONE)),
    .dst_e   (dst_e),
    .val_e   (valE_i),
    .we_m    (commit && (dst_m != RNONE)),
    .dst_m   (dst_m),
    .val_m   (valM_i)
  );

  assign dstE_o = dst_e;
  assign dstM_o = dst_m;
  assign stat_o = stat_r;

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed scenarios plus random
// instruction streams checked against a behavioural Y86-64 register model.
module tb_decode_writeback;

  localparam int          DW   = 64;
  localparam logic [63:0] RSPI = 64'd256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    icode = 4'h1, rA = 4'hF, rB = 4'hF, dbg_addr = 4'h0;
  logic          Cnd = 1'b0, imem_err = 1'b0, dmem_err = 1'b0;
  logic [DW-1:0] valE = '0, valM = '0;
  logic [DW-1:0] valA, valB, dbg_data;
  logic [3:0]    dstE, dstM;
  logic [2:0]    stat;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] m_regs [15];
  logic [2:0]  m_stat;

  decode_writeback #(.DATA_W(DW), .NREG(15), .RSP_INIT(RSPI)) dut (
    .clk_i(clk), .rst_i(rst), .icode_i(icode), .rA_i(rA), .rB_i(rB),
    .Cnd_i(Cnd), .valE_i(valE), .valM_i(valM), .imem_err_i(imem_err),
    .dmem_err_i(dmem_err), .valA_o(valA), .valB_o(valB), .dstE_o(dstE),
    .dstM_o(dstM), .stat_o(stat), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  always #20 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
  endfunction

  function automatic logic [63:0] m_rd(input logic [3:0] id);
    return (id == 4'hF) ? 64'd0 : m_regs[id];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? RSPI : 64'd0;
    m_stat = 3'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm,
                       input logic ie, input logic de);
    icode = ic; rA = ra; rB = rb; Cnd = c; valE = ve; valM = vm;
    imem_err = ie; dmem_err = de;
    #1;
  endtask

  // Applies one clock edge to both the model and the DUT.
  task automatic tick();
    logic [2:0] nxt;
    logic [3:0] de, dm;
    if (m_stat == 3'd1) begin
      if (imem_err)            nxt = 3'd3;
      else if (icode > 4'hB)   nxt = 3'd4;
      else if (dmem_err)       nxt = 3'd3;
      else if (icode == 4'h0)  nxt = 3'd2;
      else                     nxt = 3'd1;
      if (nxt == 3'd1) begin
        de = m_dst_e(icode, rB, Cnd);
        dm = m_dst_m(icode, rA);
        if (de != 4'hF) m_regs[de] = valE;
        if (dm != 4'hF) m_regs[dm] = valM;
      end
      m_stat = nxt;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vectors++; if (stat !== 3'd1) begin miscompares++; $display("FAIL reset_stat: got %0d want 1", stat); end
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r); #1;
      vectors++;
      if (dbg_data !== ((r == 4) ? RSPI : 64'd0)) begin
        miscompares++; $display("FAIL reset_reg%0d: got %0h want %0h", r, dbg_data, (r == 4) ? RSPI : 64'd0);
      end
    end
    drive(4'h0, 4'h3, 4'h4, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    vectors++; if (valA !== 64'd0 || valB !== 64'd0) begin miscompares++; $display("FAIL reset_rnone_read: got %0h/%0h want 0/0", valA, valB); end
  endtask

  task automatic test_irmovq_opq();
    drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h100, 64'h0, 1'b0, 1'b0);
    vectors++; if (dstE !== 4'h3) begin miscompares++; $display("FAIL irmovq_dstE: got %0h want 3", dstE); end
    tick();
    dbg_addr = 4'h3; #1;
    vectors++; if (dbg_data !== 64'h100) begin miscompares++; $display("FAIL irmovq_reg3: got %0h want 100", dbg_data); end
    drive(4'h6, 4'h3, 4'h3, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    vectors++; if (valA !== 64'h100 || valB !== 64'h100) begin miscompares++; $display("FAIL opq_read: got %0h/%0h want 100/100", valA, valB); end
  endtask

  task automatic test_cmov();
    drive(4'h2, 4'h3, 4'h5, 1'b0, 64'h100, 64'h0, 1'b0, 1'b0);
    vectors++; if (dstE !== 4'hF) begin miscompares++; $display("FAIL cmov_nc_dstE: got %0h want f", dstE); end
    tick();
    dbg_addr = 4'h5; #1;
    vectors++; if (dbg_data !== 64'd0) begin miscompares++; $display("FAIL cmov_nc_reg5: got %0h want 0", dbg_data); end
    drive(4'h2, 4'h3, 4'h5, 1'b1, 64'h100, 64'h0, 1'b0, 1'b0);
    vectors++; if (dstE !== 4'h5) begin miscompares++; $display("FAIL cmov_c_dstE: got %0h want 5", dstE); end
    tick();
    dbg_addr = 4'h5; #1;
    vectors++; if (dbg_data !== 64'h100) begin miscompares++; $display("FAIL cmov_c_reg5: got %0h want 100", dbg_data); end
  endtask

  task automatic test_popq_priority();
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'd264, 64'h55, 1'b0, 1'b0);
    vectors++; if (dstE !== 4'h4 || dstM !== 4'h4) begin miscompares++; $display("FAIL popq_dst: got %0h/%0h want 4/4", dstE, dstM); end
    vectors++; if (valA !== m_rd(4'h4) || valB !== m_rd(4'h4)) begin miscompares++; $display("FAIL popq_read: got %0h/%0h want %0h", valA, valB, m_rd(4'h4)); end
    tick();
    dbg_addr = 4'h4; #1;
    vectors++; if (dbg_data !== 64'h55) begin miscompares++; $display("FAIL popq_mprio: got %0h want 55", dbg_data); end
  endtask

  task automatic test_push_halt();
    drive(4'hA, 4'h3, 4'hF, 1'b0, 64'h4D, 64'h0, 1'b0, 1'b0);
    tick();
    dbg_addr = 4'h4; #1;
    vectors++; if (dbg_data !== 64'h4D) begin miscompares++; $display("FAIL push_reg4: got %0h want 4d", dbg_data); end
    drive(4'h0, 4'h4, 4'h4, 1'b0, 64'h99, 64'h77, 1'b0, 1'b0);
    tick();
    vectors++; if (stat !== 3'd2) begin miscompares++; $display("FAIL halt_stat: got %0d want 2", stat); end
    drive(4'h3, 4'hF, 4'h1, 1'b0, 64'd7, 64'h0, 1'b0, 1'b0);
    tick();
    dbg_addr = 4'h1; #1;
    vectors++; if (dbg_data !== 64'd0) begin miscompares++; $display("FAIL halted_reg1: got %0h want 0", dbg_data); end
    vectors++; if (stat !== 3'd2) begin miscompares++; $display("FAIL halt_sticky: got %0d want 2", stat); end
    for (int r = 0; r < 15; r++) begin
      dbg_addr = 4'(r); #1;
      vectors++; if (dbg_data !== m_regs[r]) begin miscompares++; $display("FAIL halt_reg%0d: got %0h want %0h", r, dbg_data, m_regs[r]); end
    end
  endtask

  task automatic test_ins_async_reset();
    do_reset();
    drive(4'h3, 4'hF, 4'h6, 1'b0, 64'hABCD, 64'h0, 1'b0, 1'b0);
    tick();
    drive(4'hC, 4'h6, 4'h6, 1'b0, 64'h1111, 64'h2222, 1'b0, 1'b0);
    tick();
    vectors++; if (stat !== 3'd4) begin miscompares++; $display("FAIL ins_stat: got %0d want 4", stat); end
    dbg_addr = 4'h6; #1;
    vectors++; if (dbg_data !== 64'hABCD) begin miscompares++; $display("FAIL ins_reg6: got %0h want abcd", dbg_data); end
    // mid-cycle assertion, then hold through an edge carrying a live write
    #5; rst = 1'b1; #1;
    model_reset();
    vectors++; if (stat !== 3'd1) begin miscompares++; $display("FAIL async_rst_stat: got %0d want 1", stat); end
    dbg_addr = 4'h6; #1;
    vectors++; if (dbg_data !== 64'd0) begin miscompares++; $display("FAIL async_rst_reg6: got %0h want 0", dbg_data); end
    drive(4'h3, 4'hF, 4'h7, 1'b0, 64'hBEEF, 64'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < 15; r++) begin
      dbg_addr = 4'(r); #1;
      vectors++; if (dbg_data !== m_regs[r]) begin miscompares++; $display("FAIL rst_override_reg%0d: got %0h want %0h", r, dbg_data, m_regs[r]); end
    end
  endtask

  task automatic test_dmem_err();
    do_reset();
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b0, 1'b0);
    tick();
    drive(4'h5, 4'h2, 4'h3, 1'b0, 64'h8, 64'hDEAD, 1'b0, 1'b1);
    tick();
    vectors++; if (stat !== 3'd3) begin miscompares++; $display("FAIL dmem_stat: got %0d want 3", stat); end
    dbg_addr = 4'h2; #1;
    vectors++; if (dbg_data !== 64'h1234) begin miscompares++; $display("FAIL dmem_reg2: got %0h want 1234", dbg_data); end
  endtask

  task automatic test_random();
    logic [3:0] ic, ra, rb, a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_stat != 3'd1) do_reset();
      ic = ($urandom_range(0, 31) < 28) ? 4'($urandom_range(1, 11)) : 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      drive(ic, ra, rb, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0);
      vectors++;
      if (valA !== m_rd(m_src_a(ic, ra)) || valB !== m_rd(m_src_b(ic, rb))) begin
        miscompares++; $display("FAIL rnd_read n=%0d ic=%0h: got %0h/%0h want %0h/%0h", n, ic, valA, valB,
                                m_rd(m_src_a(ic, ra)), m_rd(m_src_b(ic, rb)));
      end
      vectors++;
      if (dstE !== m_dst_e(ic, rb, Cnd) || dstM !== m_dst_m(ic, ra)) begin
        miscompares++; $display("FAIL rnd_dst n=%0d ic=%0h: got %0h/%0h want %0h/%0h", n, ic, dstE, dstM,
                                m_dst_e(ic, rb, Cnd), m_dst_m(ic, ra));
      end
      tick();
      vectors++; if (stat !== m_stat) begin miscompares++; $display("FAIL rnd_stat n=%0d: got %0d want %0d", n, stat, m_stat); end
      for (int k = 0; k < 3; k++) begin
        a = (k == 0) ? m_dst_e(ic, rb, Cnd) : (k == 1) ? m_dst_m(ic, ra) : 4'($urandom_range(0, 15));
        dbg_addr = a; #1;
        vectors++; if (dbg_data !== m_rd(a)) begin miscompares++; $display("FAIL rnd_reg n=%0d r%0d: got %0h want %0h", n, a, dbg_data, m_rd(a)); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_irmovq_opq();
    test_cmov();
    test_popq_priority();
    test_push_halt();
    test_ins_async_reset();
    test_dmem_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
